// File: rtl/arbiter_puf_ctrl.sv
// Arbiter PUF challenge/response sequencer: drives a static challenge and
// repeated launch edges, then majority-votes each chain's arbiter decision.
module arbiter_puf_ctrl #(
  parameter int N_STAGES  = 64,
  parameter int N_CHAINS  = 1,
  parameter int N_VOTES   = 5,
  parameter int RESET_CYC = 4,
  parameter int SETTLE    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic [N_STAGES-1:0] chal_in,
  output logic                busy,
  output logic [N_STAGES-1:0] chal_out,
  output logic                launch,
  input  logic [N_CHAINS-1:0] arb_bit,
  output logic [N_CHAINS-1:0] resp,
  output logic [N_CHAINS-1:0] stable,
  output logic                resp_xor,
  output logic                resp_valid
);

  localparam int CW   = $clog2(N_VOTES + 1);
  localparam int PMAX = (RESET_CYC > SETTLE) ? RESET_CYC : SETTLE;
  localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [PW-1:0]         r_phase;
  logic [CW-1:0]         r_votes;
  logic [N_CHAINS-1:0]   r_sync1;
  logic [N_CHAINS-1:0]   r_sync2;
  logic [CW-1:0]         r_ones      [N_CHAINS];
  logic [CW-1:0]         w_ones_next [N_CHAINS];
  logic [N_CHAINS-1:0]   w_resp_next;
  logic [N_CHAINS-1:0]   w_stable_next;
  logic                  w_low_last;
  logic                  w_high_last;
  logic                  w_votes_last;
  logic                  w_accept;

  assign w_low_last   = (r_phase == PW'(RESET_CYC - 1));
  assign w_high_last  = (r_phase == PW'(SETTLE - 1));
  assign w_votes_last = (r_votes == CW'(N_VOTES - 1));
  assign w_accept     = (r_state == S_IDLE) && req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    launch       = 1'b0;
    busy         = 1'b1;
    resp_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (req) w_state_next = S_LOW;
      end
      S_LOW: begin
        if (w_low_last) w_state_next = S_HIGH;
      end
      S_HIGH: begin
        launch = 1'b1;
        if (w_high_last) w_state_next = S_SAMPLE;
      end
      S_SAMPLE: begin
        launch       = 1'b1;
        w_state_next = w_votes_last ? S_DONE : S_LOW;
      end
      S_DONE: begin
        resp_valid   = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Phase counter restarts on every state change so LOW/HIGH durations are exact.
  always_ff @(posedge clk) begin
    if (rst || (w_state_next != r_state)) begin
      r_phase <= '0;
    end else if ((r_state == S_LOW) || (r_state == S_HIGH)) begin
      r_phase <= r_phase + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= arb_bit;
      r_sync2 <= r_sync1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CHAINS; gi++) begin : g_chain
      assign w_ones_next[gi]   = r_ones[gi] + CW'(r_sync2[gi]);
      assign w_resp_next[gi]   = (w_ones_next[gi] > CW'(N_VOTES / 2));
      assign w_stable_next[gi] = (w_ones_next[gi] == '0) ||
                                 (w_ones_next[gi] == CW'(N_VOTES));

      always_ff @(posedge clk) begin
        if (rst || w_accept) begin
          r_ones[gi] <= '0;
        end else if (r_state == S_SAMPLE) begin
          r_ones[gi] <= w_ones_next[gi];
        end
      end
    end
  endgenerate

  // Results are loaded on the final SAMPLE edge so they are visible during DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_votes  <= '0;
      chal_out <= '0;
      resp     <= '0;
      stable   <= '0;
      resp_xor <= 1'b0;
    end else if (w_accept) begin
      r_votes  <= '0;
      chal_out <= chal_in;
    end else if (r_state == S_SAMPLE) begin
      r_votes <= r_votes + CW'(1);
      if (w_votes_last) begin
        resp     <= w_resp_next;
        stable   <= w_stable_next;
        resp_xor <= ^w_resp_next;
      end
    end
  end

endmodule

// File: tb/tb_arbiter_puf_ctrl.sv
// Directed bench for arbiter_puf_ctrl: default, 4-chain, short-timing and
// single-vote configurations driven from one sequential stimulus block.
module tb_arbiter_puf_ctrl;

  logic        clk;
  logic        rst;

  logic        req_a, busy_a, launch_a, resp_a, stable_a, xor_a, valid_a;
  logic [63:0] chal_a, chal_out_a;
  logic [0:0]  arb_a;

  logic        req_b, busy_b, launch_b, xor_b, valid_b;
  logic [63:0] chal_b, chal_out_b;
  logic [3:0]  arb_b, resp_b, stable_b;

  logic        req_c, busy_c, launch_c, resp_c, stable_c, xor_c, valid_c;
  logic [7:0]  chal_c, chal_out_c;
  logic [0:0]  arb_c;

  logic        req_d, busy_d, launch_d, xor_d, valid_d;
  logic [7:0]  chal_d, chal_out_d;
  logic [1:0]  arb_d, resp_d, stable_d;

  int total = 0;
  int bad   = 0;

  arbiter_puf_ctrl u_a (
    .clk(clk), .rst(rst), .req(req_a), .chal_in(chal_a), .busy(busy_a),
    .chal_out(chal_out_a), .launch(launch_a), .arb_bit(arb_a), .resp(resp_a),
    .stable(stable_a), .resp_xor(xor_a), .resp_valid(valid_a)
  );

  arbiter_puf_ctrl #(.N_CHAINS(4)) u_b (
    .clk(clk), .rst(rst), .req(req_b), .chal_in(chal_b), .busy(busy_b),
    .chal_out(chal_out_b), .launch(launch_b), .arb_bit(arb_b), .resp(resp_b),
    .stable(stable_b), .resp_xor(xor_b), .resp_valid(valid_b)
  );

  arbiter_puf_ctrl #(.N_STAGES(8), .N_VOTES(3), .RESET_CYC(2), .SETTLE(3)) u_c (
    .clk(clk), .rst(rst), .req(req_c), .chal_in(chal_c), .busy(busy_c),
    .chal_out(chal_out_c), .launch(launch_c), .arb_bit(arb_c), .resp(resp_c),
    .stable(stable_c), .resp_xor(xor_c), .resp_valid(valid_c)
  );

  arbiter_puf_ctrl #(.N_STAGES(8), .N_CHAINS(2), .N_VOTES(1), .RESET_CYC(1), .SETTLE(3)) u_d (
    .clk(clk), .rst(rst), .req(req_d), .chal_in(chal_d), .busy(busy_d),
    .chal_out(chal_out_d), .launch(launch_d), .arb_bit(arb_d), .resp(resp_d),
    .stable(stable_d), .resp_xor(xor_d), .resp_valid(valid_d)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called in the IDLE cycle (cycle 0); returns in cycle 67, still IDLE.
  task automatic run_a(input logic [63:0] chal, input logic [4:0] pat,
                       input logic exp_r, input logic exp_s, input bit glitch);
    req_a  = 1'b1;
    chal_a = chal;
    arb_a  = pat[0];
    for (int c = 1; c <= 67; c++) begin
      tick();
      req_a  = 1'b0;
      chal_a = chal;
      if (glitch && (c == 20 || c == 66)) begin
        req_a  = 1'b1;
        chal_a = ~chal;
      end
      if (c == 67) req_a = 1'b0;
      if (c <= 65 && (c - 1) % 13 == 0) arb_a = pat[(c - 1) / 13];
      check("A.valid", valid_a, (c == 66));
      check("A.busy", busy_a, (c <= 66));
      check("A.launch", launch_a, (c <= 65) && ((c - 1) % 13 >= 4));
      check("A.chal", chal_out_a, chal);
      if (c >= 66) begin
        check("A.resp", resp_a, exp_r);
        check("A.stable", stable_a, exp_s);
        check("A.xor", xor_a, exp_r);
      end
    end
    $display("eval A chal=%h votes=%b resp=%b stable=%b xor=%b", chal, pat, resp_a, stable_a, xor_a);
  endtask

  task automatic run_b(input logic [3:0] arb, input logic [3:0] exp_r, input logic exp_x);
    req_b  = 1'b1;
    chal_b = 64'hFEDC_BA98_7654_3210;
    arb_b  = arb;
    for (int c = 1; c <= 68; c++) begin
      tick();
      req_b = 1'b0;
      check("B.valid", valid_b, (c == 66));
      if (c == 66) begin
        check("B.resp", resp_b, exp_r);
        check("B.stable", stable_b, 4'b1111);
        check("B.xor", xor_b, exp_x);
      end
    end
    $display("eval B arb=%b resp=%b stable=%b xor=%b", arb, resp_b, stable_b, xor_b);
  endtask

  task automatic run_c(input logic [2:0] pat, input logic exp_r, input logic exp_s);
    req_c  = 1'b1;
    chal_c = 8'h3C;
    arb_c  = pat[0];
    for (int c = 1; c <= 20; c++) begin
      tick();
      req_c = 1'b0;
      if (c <= 18 && (c - 1) % 6 == 0) arb_c = pat[(c - 1) / 6];
      check("C.launch", launch_c, (c <= 18) && ((c - 1) % 6 >= 2));
      check("C.valid", valid_c, (c == 19));
      check("C.chal", chal_out_c, 8'h3C);
      if (c == 19) begin
        check("C.resp", resp_c, exp_r);
        check("C.stable", stable_c, exp_s);
      end
    end
    $display("eval C votes=%b resp=%b stable=%b", pat, resp_c, stable_c);
  endtask

  task automatic run_d(input logic [1:0] arb, input logic exp_x);
    req_d  = 1'b1;
    chal_d = 8'h5A;
    arb_d  = arb;
    for (int c = 1; c <= 7; c++) begin
      tick();
      req_d = 1'b0;
      check("D.launch", launch_d, (c >= 2 && c <= 5));
      check("D.valid", valid_d, (c == 6));
      if (c == 6) begin
        check("D.resp", resp_d, arb);
        check("D.stable", stable_d, 2'b11);
        check("D.xor", xor_d, exp_x);
      end
    end
    $display("eval D arb=%b resp=%b stable=%b xor=%b", arb, resp_d, stable_d, xor_d);
  endtask

  initial begin
    rst = 1'b1;
    req_a = 1'b0; chal_a = '0; arb_a = '0;
    req_b = 1'b0; chal_b = '0; arb_b = '0;
    req_c = 1'b0; chal_c = '0; arb_c = '0;
    req_d = 1'b0; chal_d = '0; arb_d = '0;
    repeat (3) tick();
    check("rst.busy", busy_a, 1'b0);
    check("rst.launch", launch_a, 1'b0);
    check("rst.chal", chal_out_a, 64'h0);
    check("rst.resp", resp_a, 1'b0);
    check("rst.stable", stable_a, 1'b0);
    check("rst.xor", xor_a, 1'b0);
    check("rst.valid", valid_a, 1'b0);
    check("rst.b_resp", resp_b, 4'h0);
    rst = 1'b0;
    tick();

    run_a(64'h1111_2222_3333_4444, 5'b00101, 1'b0, 1'b0, 1'b0);
    run_a(64'h0F0F_0F0F_F0F0_F0F0, 5'b11011, 1'b1, 1'b0, 1'b0);
    run_a(64'h8000_0000_0000_0001, 5'b00000, 1'b0, 1'b1, 1'b0);
    run_a(64'hDEAD_BEEF_CAFE_F00D, 5'b11111, 1'b1, 1'b1, 1'b1);
    run_a(64'hA5A5_0000_FFFF_1234, 5'b11111, 1'b1, 1'b1, 1'b0);

    // Abort an evaluation with a one-cycle reset at cycle 30.
    req_a  = 1'b1;
    chal_a = 64'h7777_8888_9999_AAAA;
    arb_a  = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      tick();
      req_a = 1'b0;
      if (c == 30) rst = 1'b1;
      if (c == 31) begin
        rst = 1'b0;
        check("abort.chal", chal_out_a, 64'h0);
        check("abort.launch", launch_a, 1'b0);
        check("abort.resp", resp_a, 1'b0);
        check("abort.stable", stable_a, 1'b0);
        check("abort.xor", xor_a, 1'b0);
      end
      if (c >= 31) begin
        check("abort.busy", busy_a, 1'b0);
        check("abort.valid", valid_a, 1'b0);
      end
    end
    $display("abort A at cycle 30 busy=%b resp=%b", busy_a, resp_a);
    run_a(64'h0123_4567_89AB_CDEF, 5'b10110, 1'b1, 1'b0, 1'b0);

    run_b(4'b1011, 4'b1011, 1'b1);
    run_b(4'b0110, 4'b0110, 1'b0);
    run_c(3'b011, 1'b1, 1'b0);
    run_c(3'b111, 1'b1, 1'b1);
    run_d(2'b10, 1'b1);
    run_d(2'b00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arbiter_puf_ctrl.md
# arbiter_puf_ctrl

Parametrised challenge/response sequencer for arbiter PUF chains. It latches an N_STAGES-bit challenge and drives it, held static, onto N_CHAINS external switch-stage delay chains. It fires N_VOTES launch edges into the chains and samples each chain's arbiter decision once per launch. It returns a per-chain majority-voted response bit, a per-chain stability flag and the XOR-PUF combined bit. It sits between the challenge source (host/UART front end) and the delay chains, replacing direct single-shot chain evaluation.

## Interface
- N_STAGES, 64, challenge width = number of switch stages per chain
- N_CHAINS, 1, number of parallel chains evaluated with the same challenge
- N_VOTES, 5, launches per evaluation; odd, ≥1
- RESET_CYC, 4, cycles launch is held low before each launch edge; ≥1
- SETTLE, 8, cycles launch is held high before sampling; ≥3

- clk  in  1  single system clock
- rst  in  1  synchronous, active-high reset
- req  in  1  start evaluation; sampled only in IDLE
- chal_in  in  N_STAGES  challenge; captured on accepted req
- busy  out  1  high in every state except IDLE
- chal_out  out  N_STAGES  registered challenge to all chains
- launch  out  1  common edge input to all chains
- arb_bit  in  N_CHAINS  arbiter latch outputs (asynchronous to clk)
- resp  out  N_CHAINS  per-chain majority response
- stable  out  N_CHAINS  1 = all N_VOTES samples of that chain agreed
- resp_xor  out  1  XOR of all resp bits
- resp_valid  out  1  one-cycle pulse: resp/stable/resp_xor updated

## Operation
- arb_bit passes through an internal 2-flop synchronizer per bit. SAMPLE uses the synchronized value.
- FSM states: IDLE, LOW, HIGH, SAMPLE, DONE.
- IDLE: launch=0. When req=1: chal_out<=chal_in, clear ones counters and vote counter, go to LOW.
- LOW: launch=0 for RESET_CYC cycles, then go to HIGH.
- HIGH: launch=1 for SETTLE cycles, then go to SAMPLE.
- SAMPLE: launch=1 for one cycle. At the end of the cycle, ones[k] += sync_arb[k] and votes += 1. If votes reaches N_VOTES, go to DONE, else go to LOW.
- DONE: one cycle, then go to IDLE. At entry the outputs are written from the counters:
  - resp[k] = ones[k] > N_VOTES/2 (integer division)
  - stable[k] = (ones[k]==0) or (ones[k]==N_VOTES)
  - resp_xor = ^resp
  - resp_valid=1 in DONE only.
- Counter widths: ones[k] and votes are $clog2(N_VOTES+1) bits. Counters never wrap, because they stop at N_VOTES.
- resp, stable and resp_xor hold their values until the next DONE. chal_out holds until the next accepted req.
- req while busy=1 (including DONE) is ignored. No queueing, no effect on chal_out.
- N_VOTES=1: one launch; stable is all ones.
- Reset values: chal_out=0, launch=0, busy=0, resp=0, stable=0, resp_xor=0, resp_valid=0, FSM=IDLE, counters=0, synchronizer flops=0.
- rst mid-evaluation: all of the above apply on the next edge. No resp_valid is produced for the aborted evaluation.

## Timing
- Cycle 0 is the IDLE cycle with req=1.
- For each vote v (1..N_VOTES), with P = RESET_CYC+SETTLE+1:
  - LOW occupies cycles (v-1)·P+1 … (v-1)·P+RESET_CYC.
  - HIGH occupies the following SETTLE cycles.
  - SAMPLE occupies cycle v·P.
- resp_valid is high in cycle N_VOTES·P+1. Defaults: P=13, resp_valid at cycle 66. busy is high in cycles 1..66.
- Earliest next accept is cycle N_VOTES·P+2 (IDLE).
- launch high-time per vote is SETTLE+1 cycles; low-time is RESET_CYC cycles.
- Sampled arb_bit value: the value present at the input ≥2 cycles before the SAMPLE edge.

## Test plan
- Defaults, chal_in=64'hA5A5_0000_FFFF_1234, arb_bit held 1:
  - resp_valid only in cycle 66, with resp=1, stable=1, resp_xor=1.
  - chal_out equals chal_in from cycle 1 until the end of the evaluation.
- Defaults, arb_bit driven 1,0,1,0,0 across the five votes (changed during each LOW phase) -> resp=0, stable=0, resp_xor=0.
- N_CHAINS=4, arb_bit=4'b1011 constant -> resp=4'b1011, stable=4'b1111, resp_xor=1.
- req pulsed with a different chal_in at cycles 20 and 66 -> both ignored:
  - chal_out unchanged.
  - exactly one resp_valid.
  - a new req at cycle 67 is accepted.
- rst asserted for one cycle at cycle 30 -> on the next cycle all outputs are 0 and busy=0, with no resp_valid. A following req runs a full 66-cycle evaluation.
- Waveform check, RESET_CYC=2, SETTLE=3, N_VOTES=3 -> launch pattern 0,0,1,1,1,1 repeated 3×, resp_valid at cycle 19.
